// File: rtl/ivc_buffer_pkg.sv
// Shared flit-format constants for the input virtual-channel buffer.
// Field positions, type codes, IDLE flit and VC count live here so all files agree.
package ivc_buffer_pkg;

    localparam int NUM_VC   = 4;
    localparam int FLIT_W   = 32;
    localparam int TYPE_MSB = 31;
    localparam int TYPE_LSB = 29;
    localparam int VC_MSB   = 28;
    localparam int VC_LSB   = 27;

    localparam logic [2:0] FT_HEAD = 3'b001;
    localparam logic [2:0] FT_BODY = 3'b010;
    localparam logic [2:0] FT_IDLE = 3'b011;
    localparam logic [2:0] FT_TAIL = 3'b100;

    localparam logic [FLIT_W-1:0] IDLE_FLIT = 32'h6000_0000;

    typedef enum logic {
        PKT_CLOSED = 1'b0,
        PKT_OPEN   = 1'b1
    } pkt_state_e;

    function automatic logic [2:0] flit_type(input logic [FLIT_W-1:0] flit);
        return flit[TYPE_MSB:TYPE_LSB];
    endfunction

    function automatic logic [1:0] flit_vc(input logic [FLIT_W-1:0] flit);
        return flit[VC_MSB:VC_LSB];
    endfunction

endpackage

// File: rtl/vc_fifo.sv
// Per-VC flit FIFO: write visible at head from the next edge, no bypass; head is IDLE when empty.
// A push into a full FIFO is ignored unless a pop happens in the same cycle.
module vc_fifo
    import ivc_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic [FLIT_W-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [FLIT_W-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic [FLIT_W-1:0] mem [DEPTH];
    logic              do_push;
    logic              do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Pointers are exactly log2(DEPTH) wide, so increment wraps modulo DEPTH.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head = empty ? IDLE_FLIT : mem[rd_ptr];

endmodule

// File: rtl/ivc_buffer.sv
// Input VC buffer: classifies flits per VC, enforces HEAD/BODY/TAIL order, queues accepted flits.
// Push-to-head latency 1 edge; pops on one-hot grant; credit pulse the cycle after each pop.
module ivc_buffer
    import ivc_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [FLIT_W-1:0] data_in,
    input  logic              gnt1,
    input  logic              gnt2,
    input  logic              gnt3,
    input  logic              gnt4,
    output logic [FLIT_W-1:0] dm1_data_out,
    output logic [FLIT_W-1:0] dm2_data_out,
    output logic [FLIT_W-1:0] dm3_data_out,
    output logic [FLIT_W-1:0] dm4_data_out,
    output logic              req1,
    output logic              req2,
    output logic              req3,
    output logic              req4,
    output logic [NUM_VC-1:0] credit_out,
    output logic              err_overflow,
    output logic              err_protocol
);

    logic [NUM_VC-1:0] gnt_vec;
    logic              gnt_onehot;
    logic [NUM_VC-1:0] pop;
    logic [NUM_VC-1:0] push;
    logic [NUM_VC-1:0] full;
    logic [NUM_VC-1:0] empty;
    logic [FLIT_W-1:0] head [NUM_VC];

    logic [2:0]        ftype;
    logic [1:0]        vc;
    logic              hit_proto;
    logic              hit_ovf;
    pkt_state_e        state      [NUM_VC];
    pkt_state_e        state_next [NUM_VC];

    assign ftype = flit_type(data_in);
    assign vc    = flit_vc(data_in);

    // Only a single clean grant pops; anything else is treated as no grant at all.
    assign gnt_vec    = {gnt4, gnt3, gnt2, gnt1};
    assign gnt_onehot = (gnt_vec != '0) && ((gnt_vec & (gnt_vec - 4'd1)) == '0);
    assign pop        = gnt_onehot ? (gnt_vec & ~empty) : '0;

    always_comb begin
        push       = '0;
        hit_proto  = 1'b0;
        hit_ovf    = 1'b0;
        state_next = state;
        case (ftype)
            FT_IDLE: ;
            FT_HEAD, FT_BODY, FT_TAIL: begin
                if ((ftype == FT_HEAD) != (state[vc] == PKT_CLOSED)) begin
                    hit_proto = 1'b1;
                end else if (full[vc] && !pop[vc]) begin
                    // Dropped flits never advance the packet FSM.
                    hit_ovf = 1'b1;
                end else begin
                    push[vc] = 1'b1;
                    if (ftype == FT_HEAD)      state_next[vc] = PKT_OPEN;
                    else if (ftype == FT_TAIL) state_next[vc] = PKT_CLOSED;
                end
            end
            default: hit_proto = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_VC; i++) state[i] <= PKT_CLOSED;
            credit_out   <= '0;
            err_overflow <= 1'b0;
            err_protocol <= 1'b0;
        end else begin
            state        <= state_next;
            credit_out   <= pop;
            err_overflow <= err_overflow | hit_ovf;
            err_protocol <= err_protocol | hit_proto;
        end
    end

    for (genvar g = 0; g < NUM_VC; g++) begin : g_vc
        vc_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk       (clk),
            .reset_n   (reset_n),
            .push      (push[g]),
            .push_data (data_in),
            .pop       (pop[g]),
            .full      (full[g]),
            .empty     (empty[g]),
            .head      (head[g])
        );
    end

    assign dm1_data_out = head[0];
    assign dm2_data_out = head[1];
    assign dm3_data_out = head[2];
    assign dm4_data_out = head[3];

    assign req1 = ~empty[0];
    assign req2 = ~empty[1];
    assign req3 = ~empty[2];
    assign req4 = ~empty[3];

endmodule

// File: tb/tb_ivc_buffer.sv
// Directed bench for ivc_buffer: packet flow, overflow, protocol errors, grant corner cases, async reset.
module tb_ivc_buffer;

    localparam logic [31:0] IDLE = 32'h6000_0000;

    logic        clk;
    logic        reset_n;
    logic [31:0] data_in;
    logic [3:0]  gnt;
    logic [31:0] dm [4];
    logic [3:0]  req;
    logic [3:0]  credit_out;
    logic        err_overflow;
    logic        err_protocol;

    int n_cmp  = 0;
    int n_fail = 0;

    ivc_buffer #(.DEPTH(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .data_in      (data_in),
        .gnt1         (gnt[0]),
        .gnt2         (gnt[1]),
        .gnt3         (gnt[2]),
        .gnt4         (gnt[3]),
        .dm1_data_out (dm[0]),
        .dm2_data_out (dm[1]),
        .dm3_data_out (dm[2]),
        .dm4_data_out (dm[3]),
        .req1         (req[0]),
        .req2         (req[1]),
        .req3         (req[2]),
        .req4         (req[3]),
        .credit_out   (credit_out),
        .err_overflow (err_overflow),
        .err_protocol (err_protocol)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs at the falling edge; return 1 time unit after the rising edge.
    task automatic cycle(input logic [31:0] d, input logic [3:0] g);
        @(negedge clk);
        data_in = d;
        gnt     = g;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        data_in = IDLE;
        gnt     = 4'b0000;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        @(posedge clk); #1;
        n_cmp++; if (req !== 4'b0000) begin n_fail++; $display("FAIL rst_req: got %b want 0000", req); end
        n_cmp++; if (credit_out !== 4'b0000) begin n_fail++; $display("FAIL rst_credit: got %b want 0000", credit_out); end
        n_cmp++; if ({err_overflow, err_protocol} !== 2'b00) begin n_fail++; $display("FAIL rst_err: got %b want 00", {err_overflow, err_protocol}); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (dm[i] !== IDLE) begin n_fail++; $display("FAIL rst_dm%0d: got %h want %h", i+1, dm[i], IDLE); end
        end
        // IDLE flits change nothing
        cycle(IDLE, 4'b0000);
        cycle(IDLE, 4'b0000);
        n_cmp++; if ({req, err_overflow, err_protocol} !== 6'b0) begin n_fail++; $display("FAIL idle_nochange: got %b want 000000", {req, err_overflow, err_protocol}); end
    endtask

    task automatic test_single_packet();
        do_reset();
        cycle(32'h2800_00AA, 4'b0000);
        n_cmp++; if (req[1] !== 1'b1) begin n_fail++; $display("FAIL pkt_req2_head: got %b want 1", req[1]); end
        cycle(32'h4800_00BB, 4'b0000);
        cycle(32'h8800_00CC, 4'b0000);
        n_cmp++; if (dm[1] !== 32'h2800_00AA) begin n_fail++; $display("FAIL pkt_dm2_head: got %h want 280000aa", dm[1]); end
        n_cmp++; if (credit_out !== 4'b0000) begin n_fail++; $display("FAIL pkt_credit_idle: got %b want 0000", credit_out); end
        cycle(IDLE, 4'b0010);
        n_cmp++; if (dm[1] !== 32'h4800_00BB) begin n_fail++; $display("FAIL pkt_pop1_dm2: got %h want 480000bb", dm[1]); end
        n_cmp++; if (credit_out !== 4'b0010) begin n_fail++; $display("FAIL pkt_pop1_credit: got %b want 0010", credit_out); end
        cycle(IDLE, 4'b0010);
        n_cmp++; if (dm[1] !== 32'h8800_00CC) begin n_fail++; $display("FAIL pkt_pop2_dm2: got %h want 880000cc", dm[1]); end
        n_cmp++; if (credit_out !== 4'b0010) begin n_fail++; $display("FAIL pkt_pop2_credit: got %b want 0010", credit_out); end
        cycle(IDLE, 4'b0010);
        n_cmp++; if (dm[1] !== IDLE) begin n_fail++; $display("FAIL pkt_pop3_dm2: got %h want 60000000", dm[1]); end
        n_cmp++; if (credit_out !== 4'b0010) begin n_fail++; $display("FAIL pkt_pop3_credit: got %b want 0010", credit_out); end
        n_cmp++; if (req[1] !== 1'b0) begin n_fail++; $display("FAIL pkt_req2_empty: got %b want 0", req[1]); end
        cycle(IDLE, 4'b0000);
        n_cmp++; if (credit_out !== 4'b0000) begin n_fail++; $display("FAIL pkt_credit_end: got %b want 0000", credit_out); end
        n_cmp++; if ({err_overflow, err_protocol} !== 2'b00) begin n_fail++; $display("FAIL pkt_err: got %b want 00", {err_overflow, err_protocol}); end
    endtask

    task automatic test_overflow();
        logic [31:0] exp_seq [4];
        exp_seq[0] = 32'h4000_0002;
        exp_seq[1] = 32'h4000_0003;
        exp_seq[2] = 32'h4000_0004;
        exp_seq[3] = IDLE;
        do_reset();
        cycle(32'h2000_0001, 4'b0000);
        for (int i = 2; i <= 5; i++) cycle(32'h4000_0000 | 32'(i), 4'b0000);
        n_cmp++; if (err_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", err_overflow); end
        n_cmp++; if (err_protocol !== 1'b0) begin n_fail++; $display("FAIL ovf_no_proto: got %b want 0", err_protocol); end
        n_cmp++; if (dm[0] !== 32'h2000_0001) begin n_fail++; $display("FAIL ovf_dm1: got %h want 20000001", dm[0]); end
        for (int i = 0; i < 4; i++) begin
            cycle(IDLE, 4'b0001);
            n_cmp++; if (dm[0] !== exp_seq[i]) begin n_fail++; $display("FAIL ovf_drain%0d: got %h want %h", i, dm[0], exp_seq[i]); end
        end
        n_cmp++; if (req[0] !== 1'b0) begin n_fail++; $display("FAIL ovf_req1_empty: got %b want 0", req[0]); end
        // packet must still be open, so a TAIL is accepted
        cycle(32'h8000_0006, 4'b0000);
        n_cmp++; if (dm[0] !== 32'h8000_0006) begin n_fail++; $display("FAIL ovf_tail_dm1: got %h want 80000006", dm[0]); end
        n_cmp++; if (err_protocol !== 1'b0) begin n_fail++; $display("FAIL ovf_tail_proto: got %b want 0", err_protocol); end
        cycle(IDLE, 4'b0000);
    endtask

    task automatic test_protocol();
        do_reset();
        cycle(32'h5000_0001, 4'b0000);
        n_cmp++; if (err_protocol !== 1'b1) begin n_fail++; $display("FAIL proto_body_closed: got %b want 1", err_protocol); end
        n_cmp++; if (req[2] !== 1'b0) begin n_fail++; $display("FAIL proto_req3: got %b want 0", req[2]); end
        do_reset();
        cycle(32'h3000_0001, 4'b0000);
        cycle(32'h3000_0002, 4'b0000);
        n_cmp++; if (err_protocol !== 1'b1) begin n_fail++; $display("FAIL proto_head_open: got %b want 1", err_protocol); end
        cycle(32'h5000_0003, 4'b0000);
        n_cmp++; if (dm[2] !== 32'h3000_0001) begin n_fail++; $display("FAIL proto_dm3_head: got %h want 30000001", dm[2]); end
        cycle(IDLE, 4'b0100);
        n_cmp++; if (dm[2] !== 32'h5000_0003) begin n_fail++; $display("FAIL proto_dm3_body: got %h want 50000003", dm[2]); end
        do_reset();
        cycle(32'hE000_0000, 4'b0000);
        n_cmp++; if (err_protocol !== 1'b1) begin n_fail++; $display("FAIL proto_invalid: got %b want 1", err_protocol); end
        n_cmp++; if (req !== 4'b0000) begin n_fail++; $display("FAIL proto_invalid_req: got %b want 0000", req); end
    endtask

    task automatic test_grant_edges();
        do_reset();
        cycle(32'h2000_0011, 4'b0000);
        cycle(32'h2800_0022, 4'b0000);
        cycle(IDLE, 4'b0011);
        n_cmp++; if (credit_out !== 4'b0000) begin n_fail++; $display("FAIL gnt_multi_credit: got %b want 0000", credit_out); end
        n_cmp++; if (dm[0] !== 32'h2000_0011 || dm[1] !== 32'h2800_0022) begin n_fail++; $display("FAIL gnt_multi_dm: got %h %h want 20000011 28000022", dm[0], dm[1]); end
        cycle(IDLE, 4'b1000);
        n_cmp++; if (credit_out !== 4'b0000) begin n_fail++; $display("FAIL gnt_empty_credit: got %b want 0000", credit_out); end
        n_cmp++; if (req !== 4'b0011) begin n_fail++; $display("FAIL gnt_empty_req: got %b want 0011", req); end
        // push VC3 while popping VC1
        cycle(32'h3000_0033, 4'b0001);
        n_cmp++; if (credit_out !== 4'b0001) begin n_fail++; $display("FAIL gnt_xvc_credit: got %b want 0001", credit_out); end
        n_cmp++; if (req !== 4'b0110) begin n_fail++; $display("FAIL gnt_xvc_req: got %b want 0110", req); end
        n_cmp++; if (dm[2] !== 32'h3000_0033) begin n_fail++; $display("FAIL gnt_xvc_dm3: got %h want 30000033", dm[2]); end
    endtask

    task automatic test_full_pop();
        do_reset();
        cycle(32'h2000_0001, 4'b0000);
        for (int i = 2; i <= 4; i++) cycle(32'h4000_0000 | 32'(i), 4'b0000);
        cycle(32'h4000_0009, 4'b0001);
        n_cmp++; if (credit_out !== 4'b0001) begin n_fail++; $display("FAIL full_pop_credit: got %b want 0001", credit_out); end
        n_cmp++; if (err_overflow !== 1'b0) begin n_fail++; $display("FAIL full_pop_noerr: got %b want 0", err_overflow); end
        n_cmp++; if (dm[0] !== 32'h4000_0002) begin n_fail++; $display("FAIL full_pop_dm1: got %h want 40000002", dm[0]); end
        // occupancy still 4, so one more push without a grant overflows
        cycle(32'h4000_000A, 4'b0000);
        n_cmp++; if (err_overflow !== 1'b1) begin n_fail++; $display("FAIL full_pop_still_full: got %b want 1", err_overflow); end
    endtask

    task automatic test_async_reset();
        do_reset();
        cycle(32'h2800_0001, 4'b0000);
        cycle(32'h4800_0002, 4'b0000);
        cycle(32'hE000_0000, 4'b0000);
        cycle(IDLE, 4'b0010);
        n_cmp++; if (credit_out !== 4'b0010 || err_protocol !== 1'b1) begin n_fail++; $display("FAIL arst_pre: got %b %b want 0010 1", credit_out, err_protocol); end
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++; if (req !== 4'b0000) begin n_fail++; $display("FAIL arst_req: got %b want 0000", req); end
        n_cmp++; if (credit_out !== 4'b0000) begin n_fail++; $display("FAIL arst_credit: got %b want 0000", credit_out); end
        n_cmp++; if ({err_overflow, err_protocol} !== 2'b00) begin n_fail++; $display("FAIL arst_err: got %b want 00", {err_overflow, err_protocol}); end
        n_cmp++; if (dm[1] !== IDLE) begin n_fail++; $display("FAIL arst_dm2: got %h want 60000000", dm[1]); end
        @(negedge clk);
        gnt     = 4'b0000;
        reset_n = 1'b1;
        cycle(32'h4800_0003, 4'b0000);
        n_cmp++; if (err_protocol !== 1'b1) begin n_fail++; $display("FAIL arst_body_after: got %b want 1", err_protocol); end
        n_cmp++; if (req[1] !== 1'b0) begin n_fail++; $display("FAIL arst_req2_after: got %b want 0", req[1]); end
    endtask

    initial begin
        reset_n = 1'b0;
        data_in = IDLE;
        gnt     = 4'b0000;
        test_reset();
        test_single_packet();
        test_overflow();
        test_protocol();
        test_grant_edges();
        test_full_pop();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ivc_buffer.md
IVC_BUFFER -- requirements
Module: ivc_buffer

Interface
REQ-001 Parameter DEPTH, default 4, gives the per-VC FIFO depth in flits; it shall be a power of two and at least 2.
REQ-002 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 Port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 Port data_in, input, 32 bits: one flit per cycle from the upstream link; the IDLE flit is 32'h6000_0000.
REQ-005 Ports gnt1..gnt4, input, 1 bit each: one-hot grant from the output arbiter that pops the head flit of VC1..VC4.
REQ-006 Ports dm1_data_out..dm4_data_out, output, 32 bits each: head flit of VC1..VC4, feeding the output-select data inputs.
REQ-007 Ports req1..req4, output, 1 bit each: VC1..VC4 holds at least one flit.
REQ-008 Port credit_out, output, 4 bits: one-cycle pulse per VC when a flit is popped (bit 0 = VC1).
REQ-009 Port err_overflow, output, 1 bit: sticky; a flit was dropped because its VC FIFO was full.
REQ-010 Port err_protocol, output, 1 bit: sticky; a flit was dropped because of a packet-sequence violation.

Function
REQ-011 Flit fields: type = data_in[31:29] (3'b001 HEAD, 3'b010 BODY, 3'b100 TAIL, 3'b011 IDLE; every other code is INVALID); VC id = data_in[28:27] (0 maps to VC1 ... 3 maps to VC4).
REQ-012 IDLE flits are discarded with no state change; INVALID codes are discarded and set err_protocol.
REQ-013 Each VC has a packet FSM with states OPEN and CLOSED; the state after reset is CLOSED.
  - HEAD in CLOSED: accept and go to OPEN.
  - BODY in OPEN: accept.
  - TAIL in OPEN: accept and go to CLOSED.
  - HEAD in OPEN, or BODY/TAIL in CLOSED: drop, set err_protocol, no state change.
REQ-014 An accepted flit is written to its VC FIFO at edge N; req and dm*_data_out reflect it from edge N onward. There is no same-cycle bypass.
REQ-015 A flit for a full VC is dropped, sets err_overflow, and does not advance that VC's FSM.
  - Exception: if the same VC is popped in the same cycle, the write is accepted.
REQ-016 Pops:
  - A grant pops only when exactly one of gnt1..gnt4 is high and the granted VC is non-empty.
  - A multi-hot grant, an all-zero grant, or a grant to an empty VC causes no pop and no credit.
REQ-017 On a pop, the FIFO advances at the edge and credit_out[v] is high for exactly the following cycle.
REQ-018 dm*_data_out of an empty VC shall be 32'h6000_0000.
REQ-019 Simultaneous push and pop on the same VC: occupancy is unchanged and both take effect.
REQ-020 Simultaneous push to one VC and pop from another: both take effect independently.
REQ-021 FIFO pointers shall be log2(DEPTH) bits and wrap modulo DEPTH; occupancy shall be a log2(DEPTH)+1-bit counter ranging 0..DEPTH.
REQ-022 Error flags stay set until reset.

Reset
REQ-023 While reset_n is low, independent of clk:
  - all FIFOs are empty, all pointers are 0, and all FSMs are CLOSED;
  - req1..4 = 0, credit_out = 4'b0000, err_overflow = 0, err_protocol = 0;
  - dm1..4_data_out = 32'h6000_0000.
REQ-024 A reset asserted mid-packet discards all buffered flits. After release, the first flit accepted on any VC must be a HEAD.

Structure
REQ-025 A shared package shall hold:
  - the flit-type codes;
  - the IDLE_FLIT constant 32'h6000_0000;
  - the type/VC field positions;
  - the VC count of 4.
REQ-026 One sub-module, vc_fifo (DEPTH-parameterised, with push/pop/full/empty/head), shall be instantiated four times. The packet FSMs, grant decode and credit logic stay in ivc_buffer.

Verification
REQ-027 Single packet: HEAD/BODY/TAIL on VC2 (0x2800_00AA, 0x4800_00BB, 0x8800_00CC), no grants -> req2 = 1, dm2_data_out = 0x2800_00AA; then gnt2 for 3 cycles -> outputs 0x4800_00BB, then 0x8800_00CC, then 0x6000_0000; credit_out = 4'b0010 for 3 cycles; req2 = 0.
REQ-028 Overflow with DEPTH = 4: HEAD plus 4 BODY flits to VC1, no grant -> 4 flits stored, err_overflow = 1, and the dropped BODY does not close the packet.
REQ-029 Protocol errors: BODY to a CLOSED VC3 -> dropped, err_protocol = 1, req3 = 0; then HEAD to an OPEN VC -> dropped, and the FSM stays OPEN.
REQ-030 Grant edge cases: gnt1 and gnt2 high together, or gnt4 to an empty VC4 -> no pop, credit_out = 0, FIFOs unchanged.
REQ-031 Full plus pop: VC1 full while gnt1 and a new BODY arrive in the same cycle -> write accepted, occupancy stays 4, no error.
REQ-032 Async reset mid-packet: reset_n low between clk edges -> all outputs reach reset values immediately; after release, a BODY to the same VC sets err_protocol.
